// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply memory front end.
package mm_pkg;

  localparam int unsigned ADDR_W = 16;

  typedef enum logic [1:0] {
    IDL,
    ISSUE,
    GAP
  } b_rd_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, combinational head and synchronous flush.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full;
  logic             wr_fire;
  logic             rd_fire;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_fire   = wr_en_i & ~full;
  assign rd_fire   = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (rd_fire) rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/mem_b_read_engine.sv
// B-side read engine: pops addresses, issues credit-limited reads, buffers rows for the array.
module mem_b_read_engine
  import mm_pkg::*;
#(
  parameter int unsigned MEM_DATA_WIDTH_BYTES = 32,
  parameter int unsigned OUT_DEPTH            = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start_i,
  input  logic [ADDR_W-1:0]                 b_fifo_addr,
  input  logic                              b_fifo_empty,
  output logic                              b_fifo_decr,
  output logic [ADDR_W-1:0]                 mem_b_addr,
  output logic                              mem_b_rd,
  input  logic [MEM_DATA_WIDTH_BYTES*8-1:0] mem_b_rdata,
  input  logic                              mem_b_rvalid,
  output logic [MEM_DATA_WIDTH_BYTES*8-1:0] b_data_o,
  output logic                              b_valid_o,
  input  logic                              b_ready_i,
  output logic                              busy_o,
  output logic                              err_o
);

  localparam int unsigned DW    = MEM_DATA_WIDTH_BYTES * 8;
  localparam int unsigned CNT_W = $clog2(OUT_DEPTH) + 1;

  b_rd_state_e       state_q, state_d;
  logic [CNT_W-1:0]  credits_q, credits_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              rd_q, decr_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic              issue;
  logic              rv_live, rv_drop, rv_err;
  logic              buf_wr, pop, buf_empty;
  logic [DW-1:0]     buf_head;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDL;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = ISSUE;
    end else begin
      unique case (state_q)
        IDL:     state_d = IDL;
        ISSUE:   if (issue) state_d = GAP;
        GAP:     state_d = ISSUE;
        default: state_d = IDL;
      endcase
    end
  end

  always_comb begin
    issue = (state_q == ISSUE) && !b_fifo_empty && (credits_q != '0) && !start_i;
  end

  // A beat belongs to the stale set first; only with nothing pending at all is it an error.
  assign rv_drop = mem_b_rvalid && (drop_q != '0);
  assign rv_live = mem_b_rvalid && (drop_q == '0) && (outst_q != '0);
  assign rv_err  = mem_b_rvalid && (drop_q == '0) && (outst_q == '0);
  assign buf_wr  = rv_live && !start_i;
  assign pop     = b_valid_o && b_ready_i && !start_i;

  always_comb begin
    credits_d = credits_q;
    outst_d   = outst_q;
    drop_d    = drop_q;
    if (start_i) begin
      credits_d = CNT_W'(OUT_DEPTH);
      outst_d   = '0;
      drop_d    = drop_q + outst_q - CNT_W'(rv_drop | rv_live);
    end else begin
      credits_d = credits_q - CNT_W'(issue) + CNT_W'(pop);
      outst_d   = outst_q + CNT_W'(issue) - CNT_W'(rv_live);
      drop_d    = drop_q - CNT_W'(rv_drop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credits_q <= CNT_W'(OUT_DEPTH);
      outst_q   <= '0;
      drop_q    <= '0;
      rd_q      <= 1'b0;
      decr_q    <= 1'b0;
      addr_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
      rd_q      <= issue;
      decr_q    <= issue;
      if (issue) addr_q <= b_fifo_addr;
      err_q     <= err_q | rv_err;
    end
  end

  sync_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (DW)
  ) u_row_buf (
    .clk       (clk),
    .rst_n     (reset_n),
    .flush_i   (start_i),
    .wr_en_i   (buf_wr),
    .wr_data_i (mem_b_rdata),
    .rd_en_i   (pop),
    .rd_data_o (buf_head),
    .empty_o   (buf_empty)
  );

  assign mem_b_rd    = rd_q;
  assign b_fifo_decr = decr_q;
  assign mem_b_addr  = addr_q;
  assign err_o       = err_q;
  assign b_valid_o   = !buf_empty;
  assign b_data_o    = buf_empty ? '0 : buf_head;
  assign busy_o      = (outst_q != '0) || (drop_q != '0) || !buf_empty;

endmodule

// File: tb/tb_mem_b_read_engine.sv
// Randomized bench for mem_b_read_engine against a queue-based behavioural model.
module tb_mem_b_read_engine;

  localparam int unsigned DW    = 256;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start_i = 1'b0;
  logic [15:0]   b_fifo_addr = 16'h0;
  logic          b_fifo_empty = 1'b1;
  logic          b_fifo_decr;
  logic [15:0]   mem_b_addr;
  logic          mem_b_rd;
  logic [DW-1:0] mem_b_rdata = '0;
  logic          mem_b_rvalid = 1'b0;
  logic [DW-1:0] b_data_o;
  logic          b_valid_o;
  logic          b_ready_i = 1'b0;
  logic          busy_o;
  logic          err_o;

  always #5 clk = ~clk;

  mem_b_read_engine #(
    .MEM_DATA_WIDTH_BYTES (32),
    .OUT_DEPTH            (DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_i      (start_i),
    .b_fifo_addr  (b_fifo_addr),
    .b_fifo_empty (b_fifo_empty),
    .b_fifo_decr  (b_fifo_decr),
    .mem_b_addr   (mem_b_addr),
    .mem_b_rd     (mem_b_rd),
    .mem_b_rdata  (mem_b_rdata),
    .mem_b_rvalid (mem_b_rvalid),
    .b_data_o     (b_data_o),
    .b_valid_o    (b_valid_o),
    .b_ready_i    (b_ready_i),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   due;
    bit            live;
  } rd_t;

  logic [15:0]   afifo[$];
  rd_t           memq[$];
  logic [DW-1:0] mbuf[$];
  logic [15:0]   rd_log[$];
  int unsigned   rd_cyc_log[$];
  logic [15:0]   del_log[$];
  bit            m_err = 1'b0;
  bit            seen_rd = 1'b0;
  int unsigned   last_rd_cyc = 0;
  int unsigned   last_due = 0;
  int unsigned   cyc = 0;
  int unsigned   lat_min = 1, lat_max = 1;
  int unsigned   ready_pct = 0;
  bit            start_req = 1'b0;
  bit            stray_req = 1'b0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    b_fifo_empty = (afifo.size() == 0);
    b_fifo_addr  = (afifo.size() != 0) ? afifo[0] : 16'hDEAD;
  endtask

  task automatic push_addr(input logic [15:0] a);
    afifo.push_back(a);
    drive_fifo();
  endtask

  function automatic int unsigned live_pending();
    int unsigned n = 0;
    foreach (memq[i]) if (memq[i].live) n++;
    return n;
  endfunction

  task automatic model_reset();
    memq.delete();
    mbuf.delete();
    m_err = 1'b0;
    seen_rd = 1'b0;
    mem_b_rvalid = 1'b0;
    start_i = 1'b0;
    start_req = 1'b0;
    stray_req = 1'b0;
  endtask

  // One cycle: check what the DUT shows, then drive the next inputs and advance the model.
  task automatic step();
    rd_t           e;
    bit            have_e;
    bit            stray;
    bit            had;
    logic [DW-1:0] d;
    int unsigned   due;
    @(negedge clk);
    cyc++;
    chk("valid", b_valid_o, mbuf.size() != 0);
    if (mbuf.size() != 0) chk("data", b_data_o, mbuf[0]);
    chk("err", err_o, m_err);
    chk("decr_eq_rd", b_fifo_decr, mem_b_rd);
    if (mbuf.size() != 0 || memq.size() != 0) chk("busy", busy_o, 1'b1);
    if (mem_b_rd) begin
      chk("rd_fifo_nonempty", afifo.size() != 0, 1'b1);
      if (afifo.size() != 0) chk("rd_addr", mem_b_addr, afifo[0]);
      if (seen_rd) chk("rd_spacing", (cyc - last_rd_cyc) >= 2, 1'b1);
      seen_rd = 1'b1;
      last_rd_cyc = cyc;
      rd_log.push_back(mem_b_addr);
      rd_cyc_log.push_back(cyc);
      for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
      d[DW-1 -: 16] = mem_b_addr;
      due = cyc + $urandom_range(lat_max, lat_min);
      if (memq.size() != 0 && due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{data: d, due: due, live: 1'b1});
      chk("inflight_le_depth", (live_pending() + mbuf.size()) <= DEPTH, 1'b1);
    end
    if (b_fifo_decr && afifo.size() != 0) void'(afifo.pop_front());

    mem_b_rvalid = 1'b0;
    have_e = 1'b0;
    stray = 1'b0;
    if (stray_req) begin
      stray_req = 1'b0;
      stray = 1'b1;
      mem_b_rvalid = 1'b1;
      mem_b_rdata = {8{$urandom}};
    end else if (memq.size() != 0 && memq[0].due <= cyc) begin
      e = memq.pop_front();
      have_e = 1'b1;
      mem_b_rvalid = 1'b1;
      mem_b_rdata = e.data;
    end
    b_ready_i = ($urandom_range(99) < ready_pct);
    start_i = start_req;
    start_req = 1'b0;

    if (stray) m_err = 1'b1;
    if (start_i) begin
      mbuf.delete();
      foreach (memq[i]) memq[i].live = 1'b0;
    end else begin
      had = (mbuf.size() != 0);
      if (had && b_ready_i) del_log.push_back(mbuf.pop_front() >> (DW - 16));
      if (have_e && e.live) mbuf.push_back(e.data);
    end
    drive_fifo();
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while ((afifo.size() != 0 || memq.size() != 0 || mbuf.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk(name, n >= budget, 1'b0);
  endtask

  task automatic clear_logs();
    rd_log.delete();
    rd_cyc_log.delete();
    del_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int unsigned n0;
    int          n;
    drive_fifo();
    #1;
    chk("rst_rd", mem_b_rd, 1'b0);
    chk("rst_decr", b_fifo_decr, 1'b0);
    chk("rst_addr", mem_b_addr, 16'h0);
    chk("rst_valid", b_valid_o, 1'b0);
    chk("rst_data", b_data_o, '0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    repeat (3) step();
    reset_n = 1'b1;
    repeat (2) step();

    // Three addresses, latency 2, always ready.
    clear_logs();
    lat_min = 2; lat_max = 2; ready_pct = 100;
    push_addr(16'h0100); push_addr(16'h0120); push_addr(16'h0140);
    start_req = 1'b1;
    drain(60, "t1_timeout");
    chk("t1_nrd", rd_log.size(), 3);
    chk("t1_nrows", del_log.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (rd_log.size() > i) chk("t1_rd_addr", rd_log[i], 16'h0100 + 16'(32 * i));
      if (del_log.size() > i) chk("t1_row_addr", del_log[i], 16'h0100 + 16'(32 * i));
    end
    if (rd_cyc_log.size() == 3) begin
      chk("t1_gap01", rd_cyc_log[1] - rd_cyc_log[0], 2);
      chk("t1_gap12", rd_cyc_log[2] - rd_cyc_log[1], 2);
    end

    // Back-pressure: six addresses, four credits.
    clear_logs();
    lat_min = 1; lat_max = 3; ready_pct = 0;
    start_req = 1'b1;
    step();
    for (int i = 0; i < 6; i++) push_addr(16'h0200 + 16'(32 * i));
    repeat (30) step();
    chk("t2_stall_nrd", rd_log.size(), 4);
    chk("t2_stall_valid", b_valid_o, 1'b1);
    chk("t2_stall_buf", mbuf.size(), 4);
    ready_pct = 100;
    drain(80, "t2_timeout");
    chk("t2_nrd", rd_log.size(), 6);
    chk("t2_nrows", del_log.size(), 6);
    foreach (del_log[i]) chk("t2_row_order", del_log[i], 16'h0200 + 16'(32 * i));

    // Random traffic: handshakes collide with issues.
    clear_logs();
    lat_min = 1; lat_max = 4; ready_pct = 50;
    for (int i = 0; i < 40; i++) push_addr(16'($urandom));
    drain(1000, "t3_timeout");
    chk("t3_nrows", del_log.size(), 40);

    // start_i with one row buffered and two reads outstanding.
    clear_logs();
    lat_min = 1; lat_max = 1; ready_pct = 0;
    push_addr(16'h0A00);
    n = 0;
    while (mbuf.size() != 1 && n < 30) begin step(); n++; end
    chk("t4_buf1_timeout", n >= 30, 1'b0);
    lat_min = 8; lat_max = 8;
    push_addr(16'h0B00); push_addr(16'h0C00);
    n = 0;
    while (memq.size() != 2 && n < 30) begin step(); n++; end
    chk("t4_out2_timeout", n >= 30, 1'b0);
    start_req = 1'b1;
    step();
    step();
    chk("t4_valid_drop", b_valid_o, 1'b0);
    n = 0;
    while (memq.size() != 0 && n < 30) begin step(); n++; end
    chk("t4_late_timeout", n >= 30, 1'b0);
    step();
    chk("t4_err", err_o, 1'b0);
    chk("t4_valid_after", b_valid_o, 1'b0);
    chk("t4_busy_after", busy_o, 1'b0);
    lat_min = 2; lat_max = 2; ready_pct = 100;
    push_addr(16'h0D00);
    drain(40, "t4_timeout");
    chk("t4_nrows", del_log.size(), 1);
    if (del_log.size() != 0) chk("t4_fresh", del_log[0], 16'h0D00);

    // Stray rvalid while idle after reset.
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    repeat (2) step();
    reset_n = 1'b1;
    repeat (2) step();
    stray_req = 1'b1;
    repeat (2) step();
    chk("t5_err_set", err_o, 1'b1);
    repeat (5) step();
    chk("t5_err_sticky", err_o, 1'b1);
    chk("t5_valid", b_valid_o, 1'b0);

    // Asynchronous reset in the middle of a burst.
    reset_n = 1'b0;
    model_reset();
    repeat (2) step();
    reset_n = 1'b1;
    clear_logs();
    lat_min = 3; lat_max = 3; ready_pct = 0;
    for (int i = 0; i < 8; i++) push_addr(16'h0E00 + 16'(i));
    start_req = 1'b1;
    repeat (5) step();
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rd", mem_b_rd, 1'b0);
    chk("t6_decr", b_fifo_decr, 1'b0);
    chk("t6_addr", mem_b_addr, 16'h0);
    chk("t6_valid", b_valid_o, 1'b0);
    chk("t6_data", b_data_o, '0);
    chk("t6_busy", busy_o, 1'b0);
    chk("t6_err", err_o, 1'b0);
    model_reset();
    repeat (3) step();
    reset_n = 1'b1;
    n0 = rd_log.size();
    repeat (8) step();
    chk("t6_idle_no_rd", rd_log.size(), n0);
    start_req = 1'b1;
    repeat (25) step();
    chk("t6_credits", rd_log.size() - n0, 4);
    ready_pct = 100;
    drain(100, "t6_timeout");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_b_read_engine.md
Name: mem_b_read_engine

Overview:
- Consumer end of the B-address FIFO, whose producer is the B address generator.
- Pops one B address per transfer from a first-word-fall-through FIFO, issues a read to the B memory port, and buffers the returned row.
- Presents each row to the compute array over a valid/ready stream.
- Credit-based issue guarantees the output buffer never overflows.

Parameters:
- MEM_DATA_WIDTH_BYTES, 32, bytes per memory read beat.
- OUT_DEPTH, 4, output buffer entries; power of two, at least 2.
- CNT_W, $clog2(OUT_DEPTH)+1, local parameter: width of the credit, outstanding and drop counters.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse from the config module: begin a new matrix and flush stale state.
- b_fifo_addr  in  16  head of the address FIFO (first-word-fall-through).
- b_fifo_empty  in  1  address FIFO empty.
- b_fifo_decr  out  1  pop pulse, registered.
- mem_b_addr  out  16  memory read address, registered.
- mem_b_rd  out  1  memory read strobe, one-cycle pulse.
- mem_b_rdata  in  MEM_DATA_WIDTH_BYTES*8  read data.
- mem_b_rvalid  in  1  read data valid; returns are in order with any latency.
- b_data_o  out  MEM_DATA_WIDTH_BYTES*8  row data to the array.
- b_valid_o  out  1  b_data_o valid.
- b_ready_i  in  1  array accepts.
- busy_o  out  1  reads outstanding, or buffer not empty.
- err_o  out  1  sticky: unexpected rvalid; cleared only by reset.

Behaviour:
- Reset values: all outputs 0; state IDL; credits = OUT_DEPTH; outstanding = 0; drop = 0; buffer empty.
- FSM states:
  - IDL: go to ISSUE on start_i.
  - ISSUE: if ~b_fifo_empty and credits != 0:
    - mem_b_addr <= b_fifo_addr; mem_b_rd <= 1; b_fifo_decr <= 1, all asserted in the next cycle.
    - credits -1, outstanding +1.
    - Go to GAP.
  - GAP: one cycle so the FIFO head can update; return to ISSUE.
  - The FSM never returns to IDL by itself; the address stream has no end marker.
  - Peak issue rate is one read per 2 cycles.
- Read latency: issue decision to mem_b_rd is 1 cycle.
- Return path: on mem_b_rvalid, the beat is written into the buffer and outstanding decrements.
  - Exception: if drop != 0, the beat is discarded and drop decrements instead.
- Output side:
  - b_valid_o = buffer not empty; b_data_o = buffer head.
  - Pop the buffer on b_valid_o & b_ready_i; credits +1.
  - Minimum latency from mem_b_rvalid to b_valid_o is 1 cycle.
- Simultaneous events:
  - Issue and output handshake in the same cycle: credits unchanged.
  - Issue and rvalid in the same cycle: outstanding unchanged.
  - Buffer write and pop in the same cycle: both happen; count unchanged.
- start_i from any state:
  - Buffer flushed; credits <= OUT_DEPTH.
  - drop <= drop + outstanding; outstanding <= 0.
  - FSM goes to ISSUE; no pop or read is issued in that cycle.
  - start_i has priority over every other event in that cycle, including rvalid, which is still dropped if it arrives then.
- Overflow is impossible by construction: credits + outstanding + buffer count = OUT_DEPTH, excluding beats pending drop.
- err_o is set on mem_b_rvalid when outstanding = 0 and drop = 0; that beat is discarded.
- busy_o = (outstanding != 0) | (drop != 0) | ~buffer_empty.
- Counters are CNT_W wide; none can wrap under legal use.
- Address is passed through unmodified; no arithmetic on it.

Decomposition:
- Package mm_pkg:
  - state enum type for this FSM (IDL, ISSUE, GAP).
  - ADDR_W = 16 constant, shared with the address generator.
- Sub-module sync_fifo (DEPTH, WIDTH):
  - Output row buffer: write/read pointers with a wrap bit, combinational head, synchronous flush input.
  - Reusable for the A side.

Test Plan:
- FIFO holds 0x0100, 0x0120, 0x0140; memory returns at 2-cycle latency; b_ready_i=1 -> mem_b_rd pulses every 2 cycles carrying those addresses in order; b_fifo_decr pulses in the same cycles; three b_valid_o beats with matching data.
- b_ready_i=0, 6 addresses queued, OUT_DEPTH=4 -> exactly 4 reads issued; credits reach 0 and issue stalls. Raise b_ready_i -> remaining 2 reads issue; all 6 rows delivered in order.
- Output handshake in the same cycle as an issue -> credits unchanged; buffer count stays ≤ 4 throughout.
- start_i with 2 reads outstanding and 1 row buffered -> b_valid_o drops the next cycle; the 2 late rvalid beats are discarded; err_o stays 0. The next address delivers fresh data.
- mem_b_rvalid while idle after reset -> err_o=1 and stays set; b_valid_o stays 0.
- reset_n asserted mid-burst -> all outputs 0 asynchronously; after release the FSM is in IDL and credits = 4.
